fetch_entry_queue: RTL and testbench

Decoupling FIFO between the frontend and `id_stage`. It buffers decoded-ready fetch entries (instruction, PC, branch prediction, exception) and presents the oldest entry to the decode stage through a valid/ready handshake. On a pipeline flush it discards all contents. After it accepts a faulting entry it stops accepting further entries until the next flush.

---
 rtl/fetch_entry_queue.sv | 117 +++++++++++
 tb/tb_fetch_entry_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_queue.sv
// Fetch entry FIFO between the frontend and id_stage: circular buffer with
// flush, and an input lock that engages once a faulting entry is accepted.
package ariane_pkg;
    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [1:0]  cf;
        logic [31:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [31:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;
endpackage

module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  ariane_pkg::fetch_entry_t   fetch_entry_i,
    input  logic                       fetch_entry_valid_i,
    output logic                       fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t   fetch_entry_o,
    output logic                       fetch_entry_valid_o,
    input  logic                       fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       fault_lock_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_lock_q, fault_lock_d;

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] slot_we;
    ariane_pkg::fetch_entry_t slot_rd [DEPTH];

    // Ready ignores the consumer so no combinational path crosses the queue.
    assign fetch_entry_ready_o = (count_q < DEPTH_CNT) && !fault_lock_q && !flush_i;
    assign fetch_entry_valid_o = (count_q != '0);
    assign push                = fetch_entry_valid_i && fetch_entry_ready_o;
    assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;

    assign fetch_entry_o = slot_rd[rd_ptr_q];
    assign count_o       = count_q;
    assign fault_lock_o  = fault_lock_q;

    always_comb begin
        slot_we          = '0;
        slot_we[wr_ptr_q] = push;
    end

    // Storage is deliberately not reset; only the pointers define validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            ariane_pkg::fetch_entry_t slot_q;
            always_ff @(posedge clk_i) begin
                if (slot_we[gi]) begin
                    slot_q <= fetch_entry_i;
                end
            end
            assign slot_rd[gi] = slot_q;
        end
    endgenerate

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fault_lock_d = fault_lock_q;
        if (flush_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fault_lock_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push && fetch_entry_i.ex.valid) begin
                fault_lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fault_lock_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fault_lock_q <= fault_lock_d;
        end
    end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Randomized and directed bench for fetch_entry_queue against a queue-based
// reference model of the FIFO, flush and fault-lock rules.
module tb_fetch_entry_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    fetch_entry_t fetch_entry_i;
    logic         fetch_entry_valid_i;
    logic         fetch_entry_ready_o;
    fetch_entry_t fetch_entry_o;
    logic         fetch_entry_valid_o;
    logic         fetch_entry_ready_i;
    logic [2:0]   count_o;
    logic         fault_lock_o;

    fetch_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .count_o             (count_o),
        .fault_lock_o        (fault_lock_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks = 0;
    int           n_errors = 0;
    bit           chk_en   = 1'b0;
    string        phase    = "init";
    fetch_entry_t m_q[$];
    bit           m_lock   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] pc, input bit exv);
        fetch_entry_t e;
        e.address                        = pc;
        e.instruction                    = $urandom;
        e.branch_predict.cf              = 2'($urandom_range(3));
        e.branch_predict.predict_address = $urandom;
        e.ex.cause                       = $urandom;
        e.ex.tval                        = $urandom;
        e.ex.valid                       = exv;
        return e;
    endfunction

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input bit rst, input bit fl, input bit vin, input fetch_entry_t e, input bit rin);
        bit           exp_ready;
        bit           push;
        bit           pop;
        fetch_entry_t head;
        @(negedge clk_i);
        rst_i               = rst;
        flush_i             = fl;
        fetch_entry_valid_i = vin;
        fetch_entry_i       = e;
        fetch_entry_ready_i = rin;
        #1;
        exp_ready = (m_q.size() < DEPTH) && !m_lock && !fl;
        if (chk_en) begin
            check_val("ready", 64'(fetch_entry_ready_o), 64'(exp_ready));
            check_val("valid", 64'(fetch_entry_valid_o), 64'(m_q.size() != 0));
            check_val("count", 64'(count_o), 64'(m_q.size()));
            check_val("lock", 64'(fault_lock_o), 64'(m_lock));
            if (m_q.size() != 0) begin
                head = m_q[0];
                check_val("head_pc", 64'(fetch_entry_o.address), 64'(head.address));
                check_val("head_instr", 64'(fetch_entry_o.instruction), 64'(head.instruction));
                check_val("head_side", {fetch_entry_o.ex.cause, fetch_entry_o.branch_predict.predict_address ^ {31'd0, fetch_entry_o.ex.valid}},
                          {head.ex.cause, head.branch_predict.predict_address ^ {31'd0, head.ex.valid}});
            end
        end
        push = vin && exp_ready;
        pop  = (m_q.size() != 0) && rin;
        if (rst || fl) begin
            m_q.delete();
            m_lock = 1'b0;
        end else begin
            if (pop) begin
                head = m_q.pop_front();
                $display("[%0t] %s pop  pc=%h", $time, phase, head.address);
            end
            if (push) begin
                m_q.push_back(e);
                if (e.ex.valid) m_lock = 1'b1;
                $display("[%0t] %s push pc=%h ex=%0d", $time, phase, e.address, e.ex.valid);
            end
        end
        if (rst) chk_en = 1'b1;
    endtask

    task automatic idle(input bit rin);
        step(1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0), rin);
    endtask

    task automatic push_one(input logic [31:0] pc, input bit exv, input bit rin);
        step(1'b0, 1'b0, 1'b1, mk(pc, exv), rin);
    endtask

    initial begin
        fetch_entry_t y;
        phase = "reset";
        step(1'b1, 1'b0, 1'b0, mk(32'h0, 1'b0), 1'b0);
        step(1'b1, 1'b0, 1'b0, mk(32'h0, 1'b0), 1'b0);

        phase = "order";
        push_one(32'h0000_0A00, 1'b0, 1'b0);
        push_one(32'h0000_0B00, 1'b0, 1'b0);
        push_one(32'h0000_0C00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        phase = "full";
        for (int i = 0; i < 5; i++) push_one(32'h1000_0000 + 32'(i * 4), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0), 1'b0);

        phase = "stream";
        push_one(32'h8000_0000, 1'b0, 1'b0);
        push_one(32'h8000_0004, 1'b0, 1'b0);
        for (int n = 2; n < 22; n++) push_one(32'h8000_0000 + 32'(4 * n), 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0), 1'b0);

        phase = "fault";
        push_one(32'h0000_5000, 1'b1, 1'b0);
        y = mk(32'h0000_6000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, y, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, y, 1'b1);
        step(1'b0, 1'b1, 1'b1, y, 1'b1);
        step(1'b0, 1'b0, 1'b1, y, 1'b0);
        idle(1'b1);
        idle(1'b1);

        phase = "flush";
        for (int i = 0; i < 3; i++) push_one(32'h0000_7000 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, mk(32'h0000_7777, 1'b0), 1'b1);
        idle(1'b1);
        idle(1'b1);

        phase = "flush_fault";
        step(1'b0, 1'b1, 1'b1, mk(32'h0000_7800, 1'b1), 1'b0);
        idle(1'b0);

        phase = "midreset";
        push_one(32'h0000_9000, 1'b0, 1'b0);
        push_one(32'h0000_9004, 1'b0, 1'b0);
        push_one(32'h0000_9008, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, mk(32'h0000_9999, 1'b0), 1'b1);
        push_one(32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(19) == 0,
                 $urandom_range(3) != 0,
                 mk($urandom, $urandom_range(9) == 0),
                 $urandom_range(2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
